xadc_lockin_sequencer: RTL

//  Sequences XADC DRP reads for lock-in demodulation of the switched (PWM) sensor signal.
//  On each XADC end-of-conversion it issues one DRP read of the aux channel and waits for

---
 rtl/xadc_lockin_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/xadc_lockin_sequencer.sv
// rtl/xadc_lockin_sequencer.sv - XADC DRP read sequencer with lock-in on/off demodulation
//
// Purpose:
//   Issues one DRP read of the aux channel on every XADC end-of-conversion, then
//   classifies the returned 12-bit sample by the PWM phase captured at that EOC.
//   On- and off-phase samples go into separate saturating sums. Every N_PERIODS
//   PWM rising edges the window closes and demod = on_sum - off_sum is emitted
//   together with the per-phase sample counts.
//
// Ports:
//   clk          system clock (also the XADC dclk)
//   rst_n        asynchronous active-low reset
//   switch_pwm   asynchronous PWM drive, high = on phase
//   eoc          XADC end-of-conversion pulse
//   drp_drdy     XADC DRP data ready
//   drp_do       XADC DRP read data, sample in [15:4]
//   drp_den      DRP enable, one-cycle pulse per read
//   drp_daddr    DRP address, constant DRP_ADDR
//   demod        signed on_sum - off_sum of the last closed window
//   demod_valid  one-cycle pulse when demod/on_cnt/off_cnt update
//   on_cnt       on-phase sample count of the last closed window (saturating)
//   off_cnt      off-phase sample count of the last closed window (saturating)
//   err_timeout  sticky, a read got no drdy within TIMEOUT cycles
//   err_overrun  sticky, an eoc arrived while a read was in flight
module xadc_lockin_sequencer #(
    parameter logic [6:0] DRP_ADDR  = 7'h10,
    parameter int         N_PERIODS = 8,
    parameter int         ACC_W     = 24,
    parameter int         TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    switch_pwm,
    input  logic                    eoc,
    input  logic                    drp_drdy,
    input  logic [15:0]             drp_do,
    output logic                    drp_den,
    output logic [6:0]              drp_daddr,
    output logic signed [ACC_W:0]   demod,
    output logic                    demod_valid,
    output logic [15:0]             on_cnt,
    output logic [15:0]             off_cnt,
    output logic                    err_timeout,
    output logic                    err_overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(N_PERIODS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACC
    } state_t;

    state_t           state;
    logic             phase;
    logic [11:0]      sample;
    logic [TW-1:0]    tmo_cnt;

    logic             pwm_s1;
    logic             pwm_s2;
    logic             pwm_d1;
    logic             pwm_rise;

    logic [ACC_W-1:0] on_sum;
    logic [ACC_W-1:0] off_sum;
    logic [15:0]      on_acc_cnt;
    logic [15:0]      off_acc_cnt;
    logic [RW-1:0]    rise_cnt;

    logic             acc_on;
    logic             acc_off;
    logic             window_close;
    logic [ACC_W-1:0] on_sum_nxt;
    logic [ACC_W-1:0] off_sum_nxt;
    logic [15:0]      on_cnt_nxt;
    logic [15:0]      off_cnt_nxt;
    logic signed [ACC_W:0] demod_nxt;

    // The low nibble of the DRP status word is not part of the 12-bit sample.
    logic             unused_low_bits;
    assign unused_low_bits = ^drp_do[3:0];

    assign drp_daddr = DRP_ADDR;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [11:0]      s);
        logic [ACC_W:0] t;
        t = {1'b0, a} + {{(ACC_W - 11){1'b0}}, s};
        return t[ACC_W] ? {ACC_W{1'b1}} : t[ACC_W-1:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (&c) ? c : c + 16'd1;
    endfunction

    // Two-flop synchroniser plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_s1 <= 1'b0;
            pwm_s2 <= 1'b0;
            pwm_d1 <= 1'b0;
        end else begin
            pwm_s1 <= switch_pwm;
            pwm_s2 <= pwm_s1;
            pwm_d1 <= pwm_s2;
        end
    end

    assign pwm_rise = pwm_s2 & ~pwm_d1;

    // Read sequencer. Phase is frozen at the EOC so a PWM edge during the read
    // does not reclassify the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            phase       <= 1'b0;
            sample      <= 12'd0;
            tmo_cnt     <= '0;
            drp_den     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            drp_den <= 1'b0;
            if (eoc && (state != S_IDLE)) begin
                err_overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (eoc) begin
                        phase   <= pwm_s2;
                        drp_den <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (drp_drdy) begin
                        sample <= drp_do[15:4];
                        state  <= S_ACC;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_ACC: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Post-accumulation values; a sample landing in the closing cycle is
    // folded into the window being emitted rather than the next one.
    assign acc_on       = (state == S_ACC) && phase;
    assign acc_off      = (state == S_ACC) && !phase;
    assign on_sum_nxt   = acc_on  ? sat_add(on_sum, sample)  : on_sum;
    assign off_sum_nxt  = acc_off ? sat_add(off_sum, sample) : off_sum;
    assign on_cnt_nxt   = acc_on  ? sat_inc(on_acc_cnt)      : on_acc_cnt;
    assign off_cnt_nxt  = acc_off ? sat_inc(off_acc_cnt)     : off_acc_cnt;
    assign demod_nxt    = $signed({1'b0, on_sum_nxt}) - $signed({1'b0, off_sum_nxt});
    assign window_close = pwm_rise && (rise_cnt == RW'(N_PERIODS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_sum      <= '0;
            off_sum     <= '0;
            on_acc_cnt  <= 16'd0;
            off_acc_cnt <= 16'd0;
            rise_cnt    <= '0;
            demod       <= '0;
            demod_valid <= 1'b0;
            on_cnt      <= 16'd0;
            off_cnt     <= 16'd0;
        end else begin
            demod_valid <= 1'b0;
            if (window_close) begin
                demod       <= demod_nxt;
                on_cnt      <= on_cnt_nxt;
                off_cnt     <= off_cnt_nxt;
                demod_valid <= 1'b1;
                on_sum      <= '0;
                off_sum     <= '0;
                on_acc_cnt  <= 16'd0;
                off_acc_cnt <= 16'd0;
                rise_cnt    <= '0;
            end else begin
                on_sum      <= on_sum_nxt;
                off_sum     <= off_sum_nxt;
                on_acc_cnt  <= on_cnt_nxt;
                off_acc_cnt <= off_cnt_nxt;
                if (pwm_rise) begin
                    rise_cnt <= rise_cnt + RW'(1);
                end
            end
        end
    end

endmodule
